wasca_nios2_gen2_0_cpu_mul_combine: RTL

//   Downstream stage of the CPU multiplier cell. Takes the three registered 16x16

---
 rtl/wasca_nios2_gen2_0_cpu_mul_combine_if.sv | 26 ++
 rtl/wasca_nios2_gen2_0_cpu_mul_combine.sv | 131 +++++++++++++
 2 files changed

// File: rtl/wasca_nios2_gen2_0_cpu_mul_combine_if.sv
// Handshake bundle carrying partial products into the multiplier combine stage
// and the combined result out toward A-stage writeback.
interface wasca_nios2_gen2_0_cpu_mul_combine_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_p1;
  logic [31:0]      in_p2;
  logic [31:0]      in_p3;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_p1, in_p2, in_p3, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_p1, in_p2, in_p3, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/wasca_nios2_gen2_0_cpu_mul_combine.sv
// Combines three 16x16 partial products into the low 32 bits of src1*src2 over a
// two-stage valid/ready pipeline. Optional input skid buffer: WASCA_MUL_COMBINE_SKID_EN.
module wasca_nios2_gen2_0_cpu_mul_combine #(
  parameter int TAG_W = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  wasca_nios2_gen2_0_cpu_mul_combine_if.slave  bus
);

  logic             s1_valid_r;
  logic [15:0]      mid_r;
  logic [31:0]      p1_r;
  logic [TAG_W-1:0] tag1_r;

  logic             out_valid_r;
  logic [31:0]      out_result_r;
  logic [TAG_W-1:0] out_tag_r;

  logic             s2_en_s;
  logic             s1_en_s;
  logic             in_ready_s;
  logic             acc_s;
  logic             src_valid_s;
  logic [15:0]      src_mid_s;
  logic [31:0]      src_p1_s;
  logic [TAG_W-1:0] src_tag_s;

  // Stage enables: a stage may advance when it is empty or its successor advances.
  always_comb begin
    s2_en_s = ~out_valid_r | bus.out_ready;
    s1_en_s = ~s1_valid_r | s2_en_s;
  end

`ifdef WASCA_MUL_COMBINE_SKID_EN
  logic             skid_valid_r;
  logic [15:0]      skid_mid_r;
  logic [31:0]      skid_p1_r;
  logic [TAG_W-1:0] skid_tag_r;

  // Ready comes straight from the skid flop; a parked entry has priority into S1.
  always_comb begin
    in_ready_s  = ~skid_valid_r;
    acc_s       = bus.in_valid & in_ready_s & ~flush;
    src_valid_s = skid_valid_r | acc_s;
    if (skid_valid_r) begin
      src_mid_s = skid_mid_r;
      src_p1_s  = skid_p1_r;
      src_tag_s = skid_tag_r;
    end else begin
      src_mid_s = 16'(bus.in_p2 + bus.in_p3);
      src_p1_s  = bus.in_p1;
      src_tag_s = bus.in_tag;
    end
  end

  // Skid entry: parks an accepted input while S1 is blocked, drains when S1 advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_r <= 1'b0;
      skid_mid_r   <= 16'h0000;
      skid_p1_r    <= 32'h0000_0000;
      skid_tag_r   <= {TAG_W{1'b0}};
    end else begin
      if (flush | s1_en_s) begin
        skid_valid_r <= 1'b0;
      end else if (acc_s) begin
        skid_valid_r <= 1'b1;
      end
      if (acc_s & ~s1_en_s) begin
        skid_mid_r <= 16'(bus.in_p2 + bus.in_p3);
        skid_p1_r  <= bus.in_p1;
        skid_tag_r <= bus.in_tag;
      end
    end
  end
`else
  // Without a skid entry, ready is simply S1's ability to advance.
  always_comb begin
    in_ready_s  = s1_en_s;
    acc_s       = bus.in_valid & in_ready_s & ~flush;
    src_valid_s = acc_s;
    src_mid_s   = 16'(bus.in_p2 + bus.in_p3);
    src_p1_s    = bus.in_p1;
    src_tag_s   = bus.in_tag;
  end
`endif

  // S1: fold the two cross products into a 16-bit middle term (carry out is beyond bit 31).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      mid_r      <= 16'h0000;
      p1_r       <= 32'h0000_0000;
      tag1_r     <= {TAG_W{1'b0}};
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_en_s) begin
      s1_valid_r <= src_valid_s;
      if (src_valid_s) begin
        mid_r  <= src_mid_s;
        p1_r   <= src_p1_s;
        tag1_r <= src_tag_s;
      end
    end
  end

  // S2: final add; output registers hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_result_r <= 32'h0000_0000;
      out_tag_r    <= {TAG_W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (s2_en_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_result_r <= p1_r + {mid_r, 16'h0000};
        out_tag_r    <= tag1_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_tag    = out_tag_r;

endmodule
